// File: rtl/led_gui_pkg.sv
// Shared types and constants for the LED GUI key front-end.
// Holds the sequencer state encoding, key indices and small helper functions.
package led_gui_pkg;

  localparam int KEY_NUM   = 4;
  localparam int KEY_IDX_W = $clog2(KEY_NUM);

  localparam int KEY_UP   = 0;
  localparam int KEY_DOWN = 1;
  localparam int KEY_OK   = 2;
  localparam int KEY_BACK = 3;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HOLD,
    REPEAT,
    DB_REL
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Lowest set bit wins, so key 0 has the highest priority.
  function automatic logic [KEY_IDX_W-1:0] lowest_set(input logic [KEY_NUM-1:0] v);
    logic [KEY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/led_gui_key_sync.sv
// Two-flop synchronizer for the raw, active-low key pins.
// Resets to all-ones so every key reads as released straight out of reset.
module led_gui_key_sync
  import led_gui_pkg::*;
#(
  parameter int WIDTH = KEY_NUM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample their inputs from before the edge, giving a true two-flop chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/led_gui_key_sequencer.sv
// Debounce, arbitration and auto-repeat for four push-buttons, producing
// registered one-hot, one-cycle command pulses on config_sig.
module led_gui_key_sequencer
  import led_gui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned REPEAT_EN       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KEY_NUM-1:0]   key_in,
  output logic [KEY_NUM-1:0]   config_sig,
  output logic                 key_busy,
  output logic [KEY_IDX_W-1:0] key_sel
);

  localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam int          CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

  logic [KEY_NUM-1:0]   key_sync;
  logic [KEY_NUM-1:0]   key_act;
  logic                 sel_held;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [KEY_IDX_W-1:0] sel_q, sel_d;
  logic [KEY_NUM-1:0]   cfg_q, cfg_d;

  led_gui_key_sync #(.WIDTH(KEY_NUM)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(key_in),
    .sync_o (key_sync)
  );

  assign key_act  = ~key_sync;
  assign sel_held = key_act[sel_q];

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    cfg_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (|key_act) begin
          state_d = DB_PRESS;
          sel_d   = lowest_set(key_act);
          cnt_d   = '0;
        end
      end
      DB_PRESS: begin
        if (!sel_held) begin
          state_d = IDLE;
          sel_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          cfg_d[sel_q] = 1'b1;
          state_d      = HOLD;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!sel_held) begin
          state_d = DB_REL;
          cnt_d   = '0;
        end else if ((REPEAT_EN != 0) && (cnt_q == RD_LAST)) begin
          cfg_d[sel_q] = 1'b1;
          state_d      = REPEAT;
          cnt_d        = '0;
        end else if (cnt_q != '1) begin
          // Without auto-repeat a long hold parks the counter at full scale.
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!sel_held) begin
          state_d = DB_REL;
          cnt_d   = '0;
        end else if (cnt_q == RR_LAST) begin
          cfg_d[sel_q] = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_REL: begin
        if (sel_held) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          sel_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset also drops any pulse decided on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      cfg_q   <= cfg_d;
    end
  end

  assign config_sig = cfg_q;
  assign key_busy   = (state_q != IDLE);
  assign key_sel    = sel_q;

endmodule

// File: tb/tb_led_gui_key_sequencer.sv
// Directed bench for led_gui_key_sequencer with short debounce/repeat timing.
// Pulse times are logged as the edge at which a downstream register captures them.
module tb_led_gui_key_sequencer;
  import led_gui_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in, key_in_nr;
  logic [3:0] config_sig, config_sig_nr;
  logic       key_busy, key_busy_nr;
  logic [1:0] key_sel, key_sel_nr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int e0, e1;

  int pulse_cyc[$];
  int pulse_val[$];
  int nr_cyc[$];
  int nr_val[$];
  int prev_cfg    = 0;
  int prev_cfg_nr = 0;

  led_gui_key_sequencer #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(5), .REPEAT_EN(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .config_sig(config_sig), .key_busy(key_busy), .key_sel(key_sel)
  );

  led_gui_key_sequencer #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(5), .REPEAT_EN(0)
  ) u_nr (
    .clk(clk), .rst_n(rst_n), .key_in(key_in_nr),
    .config_sig(config_sig_nr), .key_busy(key_busy_nr), .key_sel(key_sel_nr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Wait for the falling edge following rising edge number 'edge_n'.
  task automatic wait_edge(input int edge_n);
    while (cyc < edge_n) @(negedge clk);
  endtask

  task automatic clear_logs();
    pulse_cyc.delete(); pulse_val.delete();
    nr_cyc.delete();    nr_val.delete();
  endtask

  always @(negedge clk) begin
    if (config_sig != 4'b0000) begin
      check("onehot", $countones(config_sig), 1);
      check("no_back_to_back", prev_cfg, 0);
      pulse_cyc.push_back(cyc + 1);
      pulse_val.push_back(int'(config_sig));
    end
    prev_cfg = int'(config_sig);
  end

  always @(negedge clk) begin
    if (config_sig_nr != 4'b0000) begin
      check("nr_onehot", $countones(config_sig_nr), 1);
      check("nr_no_back_to_back", prev_cfg_nr, 0);
      nr_cyc.push_back(cyc + 1);
      nr_val.push_back(int'(config_sig_nr));
    end
    prev_cfg_nr = int'(config_sig_nr);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, at edge %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    key_in    = 4'hF;
    key_in_nr = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_cfg",  32'(config_sig), 0);
    check("rst_busy", 32'(key_busy), 0);
    check("rst_sel",  32'(key_sel), 0);
    check("rst_nr_busy", 32'(key_busy_nr), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean press of key 0, held 8 cycles.
    clear_logs();
    e0 = cyc + 1;
    key_in = 4'b1110;
    wait_edge(e0 + 2);
    check("t1_busy_on", 32'(key_busy), 1);
    check("t1_sel", 32'(key_sel), KEY_UP);
    wait_edge(e0 + 7);
    key_in = 4'hF;
    wait_edge(e0 + 13);
    check("t1_busy_dbrel", 32'(key_busy), 1);
    wait_edge(e0 + 14);
    check("t1_busy_off", 32'(key_busy), 0);
    check("t1_sel_idle", 32'(key_sel), 0);
    wait_edge(e0 + 18);
    check("t1_npulse", pulse_cyc.size(), 1);
    check("t1_pulse_t", pulse_cyc[0], e0 + 7);
    check("t1_pulse_v", pulse_val[0], 1);

    // Bounce on key 1: low 2, high 1, then stable low.
    clear_logs();
    e0 = cyc + 1;
    key_in = 4'b1101;
    wait_edge(e0 + 1);
    key_in = 4'hF;
    wait_edge(e0 + 2);
    key_in = 4'b1101;
    wait_edge(e0 + 4);
    check("t2_glitch_idle", 32'(key_busy), 0);
    wait_edge(e0 + 5);
    check("t2_redetect", 32'(key_busy), 1);
    check("t2_sel", 32'(key_sel), KEY_DOWN);
    wait_edge(e0 + 11);
    key_in = 4'hF;
    wait_edge(e0 + 22);
    check("t2_npulse", pulse_cyc.size(), 1);
    check("t2_pulse_t", pulse_cyc[0], e0 + 10);
    check("t2_pulse_v", pulse_val[0], 2);
    check("t2_busy_off", 32'(key_busy), 0);

    // Auto-repeat on key 2, held 40 cycles.
    clear_logs();
    e0 = cyc + 1;
    key_in = 4'b1011;
    wait_edge(e0 + 39);
    key_in = 4'hF;
    wait_edge(e0 + 55);
    check("t3_npulse", pulse_cyc.size(), 7);
    for (int i = 0; i < 7; i++) begin
      int exp_t;
      exp_t = (i == 0) ? e0 + 7 : e0 + 12 + 5 * i;
      check($sformatf("t3_pulse_t%0d", i), pulse_cyc[i], exp_t);
      check($sformatf("t3_pulse_v%0d", i), pulse_val[i], 4);
    end
    check("t3_busy_off", 32'(key_busy), 0);

    // Same hold with auto-repeat disabled.
    clear_logs();
    e0 = cyc + 1;
    key_in_nr = 4'b1011;
    wait_edge(e0 + 20);
    check("t4_nr_busy", 32'(key_busy_nr), 1);
    check("t4_nr_sel", 32'(key_sel_nr), KEY_OK);
    wait_edge(e0 + 39);
    key_in_nr = 4'hF;
    wait_edge(e0 + 55);
    check("t4_npulse", nr_cyc.size(), 1);
    check("t4_pulse_t", nr_cyc[0], e0 + 7);
    check("t4_pulse_v", nr_val[0], 4);
    check("t4_nr_busy_off", 32'(key_busy_nr), 0);
    check("t4_main_quiet", pulse_cyc.size(), 0);

    // Keys 1 and 3 together; key 1 wins, key 3 served after key 1 releases.
    clear_logs();
    e0 = cyc + 1;
    key_in = 4'b0101;
    wait_edge(e0 + 2);
    check("t5_sel_k1", 32'(key_sel), KEY_DOWN);
    wait_edge(e0 + 8);
    key_in = 4'b0111;
    wait_edge(e0 + 15);
    check("t5_idle_gap", 32'(key_busy), 0);
    wait_edge(e0 + 16);
    check("t5_sel_k3", 32'(key_sel), KEY_BACK);
    wait_edge(e0 + 23);
    key_in = 4'hF;
    wait_edge(e0 + 34);
    check("t5_npulse", pulse_cyc.size(), 2);
    check("t5_p0_t", pulse_cyc[0], e0 + 7);
    check("t5_p0_v", pulse_val[0], 2);
    check("t5_p1_t", pulse_cyc[1], e0 + 21);
    check("t5_p1_v", pulse_val[1], 8);

    // Reset while DB_PRESS counter is 2.
    clear_logs();
    e0 = cyc + 1;
    key_in = 4'b1110;
    wait_edge(e0 + 4);
    check("t6_busy_pre", 32'(key_busy), 1);
    rst_n = 1'b0;
    wait_edge(e0 + 5);
    check("t6_busy_rst", 32'(key_busy), 0);
    check("t6_sel_rst", 32'(key_sel), 0);
    check("t6_sync_rst", 32'(u_dut.key_sync), 32'hF);
    rst_n  = 1'b1;
    key_in = 4'hF;
    wait_edge(e0 + 6);
    check("t6_busy_after", 32'(key_busy), 0);
    wait_edge(e0 + 12);
    check("t6_no_pulse", pulse_cyc.size(), 0);

    e1 = cyc + 1;
    key_in = 4'b1110;
    wait_edge(e1 + 7);
    key_in = 4'hF;
    wait_edge(e1 + 20);
    check("t6_npulse", pulse_cyc.size(), 1);
    check("t6_pulse_t", pulse_cyc[0], e1 + 7);
    check("t6_pulse_v", pulse_val[0], 1);
    check("t6_busy_end", 32'(key_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
